// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch -> decode path: default widths, the
// queue entry layout and the constants the decode side uses for bubbles.
package fetch_pkg;

    localparam int PC_W            = 64;
    localparam int INSTR_W         = 32;
    localparam int INSTR_MEM_WORDS = 1024;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               inv_addr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry storage for the fetch/decode queue: one synchronous write port and
// one asynchronous read port. Contents are not reset; occupancy tracking in
// the parent decides which slots are meaningful.
module fetch_queue_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 97,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the fetched entry into its slot.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode. Buffers {pc, instr, inv_addr}
// entries, drops everything on a redirect, and stops accepting after an
// invalid-address fetch so that the faulting entry is the last one decode
// sees until the next redirect.
module fetch_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic                       in_inv_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic                       out_inv_addr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               inv_addr;
    } entry_t;

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          poison;
    logic          full, push, pop;
    entry_t        wentry, rentry;

    // Full is taken from the count; pointers alone cannot tell full from empty.
    assign full      = (count == CW'(DEPTH));
    assign in_ready  = !full && !poison && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wentry = '{pc: in_pc, instr: in_instr, inv_addr: in_inv_addr};

    fetch_queue_storage #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wentry),
        .raddr (rd_ptr),
        .rdata (rentry)
    );

    // Head fields read straight from storage; forced to zero when empty so
    // stale slot contents never leak onto the decode interface.
    always_comb begin
        out_pc       = '0;
        out_instr    = '0;
        out_inv_addr = 1'b0;
        if (out_valid) begin
            out_pc       = rentry.pc;
            out_instr    = rentry.instr;
            out_inv_addr = rentry.inv_addr;
        end
    end

    // Pointer, occupancy and poison tracking; a redirect wins over any
    // push or pop in the same cycle (push is already blocked via in_ready).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            poison <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            poison <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push && in_inv_addr) poison <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: a reference queue of expected entries is
// filled when the bench offers an entry the model says must be accepted,
// and drained when the model says decode consumes the head.
module tb_fetch_decode_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc = '0;
    logic [INSTR_W-1:0] in_instr = '0;
    logic               in_inv_addr = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_inv_addr;
    logic [2:0]         count;

    int total = 0;
    int bad   = 0;

    fetch_entry_t mq[$];
    logic         mpoison = 1'b0;

    fetch_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_inv_addr  (in_inv_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_inv_addr (out_inv_addr),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; comparisons follow 1ns later.
    task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                         input logic inv, input logic ordy, input logic fl);
        in_valid    = v;
        in_pc       = pc;
        in_instr    = ins;
        in_inv_addr = inv;
        out_ready   = ordy;
        flush       = fl;
        #1;
    endtask

    // Advance one clock and update the reference model with what must happen.
    task automatic tick();
        logic acc, pop;
        fetch_entry_t e;
        acc = in_valid && (mq.size() < DEPTH) && !mpoison && !flush;
        pop = (mq.size() > 0) && out_ready;
        e   = '{pc: in_pc, instr: in_instr, inv_addr: in_inv_addr};
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            mpoison = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                if (e.inv_addr) mpoison = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mpoison = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, '0, '0, 0, 0, 0);
        rst = 1'b1;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (out_pc !== '0) begin bad++; $display("FAIL reset_out_pc got=%0h exp=0", out_pc); end
        total++; if (out_instr !== '0) begin bad++; $display("FAIL reset_out_instr got=%0h exp=0", out_instr); end
        total++; if (out_inv_addr !== 1'b0) begin bad++; $display("FAIL reset_out_inv got=%0b exp=0", out_inv_addr); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        do_reset();
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, PC_W'(4 * i), INSTR_W'(32'h00100093 + (i << 7)), 0, 0, 0);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%0b exp=1", i, in_ready); end
            total++; if (count !== 3'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
            tick();
        end
        drive(1, 64'h10, 32'hdeadbeef, 0, 0, 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", in_ready); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
        tick();
        drive(0, '0, '0, 0, 1, 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%0b exp=0", in_ready); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, out_valid); end
            total++; if (out_pc !== mq[0].pc) begin bad++; $display("FAIL drain_pc[%0d] got=%0h exp=%0h", i, out_pc, mq[0].pc); end
            total++; if (out_instr !== mq[0].instr) begin bad++; $display("FAIL drain_instr[%0d] got=%0h exp=%0h", i, out_instr, mq[0].instr); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drained_valid got=%0b exp=0", out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drained_count got=%0d exp=0", count); end
        total++; if (out_pc !== '0) begin bad++; $display("FAIL drained_pc got=%0h exp=0", out_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, PC_W'(4 * i), INSTR_W'(32'h100 + i), 0, 0, 0);
            tick();
        end
        for (int i = 2; i < 12; i++) begin
            drive(1, PC_W'(4 * i), INSTR_W'(32'h100 + i), 0, 1, 0);
            total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count); end
            total++; if (out_pc !== mq[0].pc) begin bad++; $display("FAIL b2b_pc[%0d] got=%0h exp=%0h", i, out_pc, mq[0].pc); end
            total++; if (out_instr !== mq[0].instr) begin bad++; $display("FAIL b2b_instr[%0d] got=%0h exp=%0h", i, out_instr, mq[0].instr); end
            tick();
        end
        drive(0, '0, '0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            total++; if (out_pc !== mq[0].pc) begin bad++; $display("FAIL b2b_tail_pc[%0d] got=%0h exp=%0h", i, out_pc, mq[0].pc); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, PC_W'(4 * i), INSTR_W'(32'h200 + i), 0, 0, 0);
            tick();
        end
        drive(1, 64'h50, 32'h250, 0, 1, 1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_cycle_valid got=%0b exp=1", out_valid); end
        tick();
        drive(0, '0, '0, 0, 0, 0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        drive(1, 64'h100, 32'h300, 0, 0, 0);
        tick();
        drive(0, '0, '0, 0, 0, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_next_valid got=%0b exp=1", out_valid); end
        total++; if (out_pc !== 64'h100) begin bad++; $display("FAIL flush_next_pc got=%0h exp=100", out_pc); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL flush_next_count got=%0d exp=1", count); end
    endtask

    task automatic test_poison();
        do_reset();
        drive(1, 64'h0, 32'h400, 0, 0, 0);
        tick();
        drive(1, 64'h6, 32'h401, 1, 0, 0);
        tick();
        drive(1, 64'h8, 32'h402, 0, 1, 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL poison_ready got=%0b exp=0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            total++; if (out_pc !== mq[0].pc) begin bad++; $display("FAIL poison_pc[%0d] got=%0h exp=%0h", i, out_pc, mq[0].pc); end
            total++; if (out_inv_addr !== mq[0].inv_addr) begin bad++; $display("FAIL poison_inv[%0d] got=%0b exp=%0b", i, out_inv_addr, mq[0].inv_addr); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL poison_drained got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL poison_hold_ready got=%0b exp=0", in_ready); end
        drive(0, '0, '0, 0, 0, 1);
        tick();
        drive(0, '0, '0, 0, 0, 0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL poison_cleared got=%0b exp=1", in_ready); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, PC_W'(4 * i + 'h40), INSTR_W'(32'h500 + i), 0, 0, 0);
            tick();
        end
        drive(0, '0, '0, 0, 0, 0);
        total++; if (count !== 3'd3) begin bad++; $display("FAIL areset_pre_count got=%0d exp=3", count); end
        #1 rst = 1'b1;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%0b exp=0", out_valid); end
        total++; if (out_pc !== '0) begin bad++; $display("FAIL areset_pc got=%0h exp=0", out_pc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%0b exp=1", in_ready); end
        mq.delete();
        mpoison = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_empty_pop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, '0, '0, 0, 1, 0);
            total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_count[%0d] got=%0d exp=0", i, count); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_valid[%0d] got=%0b exp=0", i, out_valid); end
            tick();
        end
        drive(1, 64'h200, 32'h600, 0, 0, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nobypass_valid got=%0b exp=0", out_valid); end
        tick();
        drive(0, '0, '0, 0, 0, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL empty_push_valid got=%0b exp=1", out_valid); end
        total++; if (out_pc !== mq[0].pc) begin bad++; $display("FAIL empty_push_pc got=%0h exp=%0h", out_pc, mq[0].pc); end
        total++; if (out_instr !== mq[0].instr) begin bad++; $display("FAIL empty_push_instr got=%0h exp=%0h", out_instr, mq[0].instr); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL empty_push_count got=%0d exp=1", count); end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_poison();
        test_async_reset();
        test_empty_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Instruction queue between the fetch stage and the decode stage. It buffers fetched {PC, instruction, invalid-address flag} entries so fetch can run ahead while decode stalls. It discards everything on a control-flow redirect (flush). It stops accepting entries after an invalid-address fetch until the next flush, so the faulting entry is the last one that reaches decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PC_W, 64, PC width.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  redirect from branch/jump resolution; discards all contents.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept an entry this cycle.
- in_pc  in  PC_W  PC of the fetched instruction.
- in_instr  in  INSTR_W  fetched instruction word.
- in_inv_addr  in  1  fetch flagged a misaligned or out-of-range PC (PC[1:0]!=0 or word index >1023).
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  PC_W  head PC.
- out_instr  out  INSTR_W  head instruction.
- out_inv_addr  out  1  head entry carries an invalid-address fault.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset:
  - Asynchronous, on rst high; reset dominates all other inputs.
  - Clears count=0, rd_ptr=0, wr_ptr=0 and the poison bit.
  - Resulting outputs: out_valid=0, out_pc=0, out_instr=0, out_inv_addr=0, in_ready=1.
  - Storage contents are don't-care.
  - Reset mid-stream drops all entries; nothing is replayed.
- Push: occurs when in_valid && in_ready at the clock edge. The entry is written at wr_ptr, wr_ptr advances modulo DEPTH, and the entry is visible at the head one cycle later at the earliest. There is no combinational bypass.
- Pop: occurs when out_valid && out_ready at the clock edge. rd_ptr advances modulo DEPTH.
- Head outputs:
  - Driven directly from storage[rd_ptr] when count>0.
  - When count==0: out_valid=0, out_pc=0, out_instr=0, out_inv_addr=0.
- in_ready = (count<DEPTH) && !poison && !flush.
  - A full queue does not accept a push in the same cycle as a pop; in_ready is 0 whenever full.
- out_valid = (count>0). It is independent of flush in the current cycle; decode ignores a head consumed in a flush cycle.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Pop while empty: ignored. Push while in_ready=0: ignored, and fetch holds its data.
- Poison:
  - Set on a push with in_inv_addr=1.
  - While set, in_ready=0. The faulting entry still drains to decode normally.
  - Cleared only by flush or rst.
- Flush:
  - Synchronous; takes priority over push and pop in the same cycle.
  - Next cycle: count=0, pointers=0, poison=0, out_valid=0.
  - Any in_valid on a flush cycle is dropped, since in_ready=0 that cycle.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy comes from count, not from pointer compare.
- Count arithmetic: +1 on push only, −1 on pop only, otherwise unchanged. The count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package fetch_pkg:
  - PC_W, INSTR_W.
  - Typedef fetch_entry_t {pc, instr, inv_addr}.
  - Constants INSTR_MEM_WORDS=1024 and NOP_INSTR=32'h00000013, for the decode-side bubble.
- One sub-module, fetch_queue_storage: a DEPTH x entry register array with write port (we, waddr, wdata) and asynchronous read port (raddr → rdata).
- Pointers, count, poison and handshake logic stay in fetch_decode_queue.

Test Plan:
1. Fill, then drain:
   - Reset, hold out_ready=0, push PCs 0x0, 0x4, 0x8, 0xC with instrs 0x00100093.. → in_ready drops after 4th push, count=4.
   - Then out_ready=1 → heads emerge 0x0, 0x4, 0x8, 0xC in order, out_valid=0 after 4 pops.
2. Simultaneous push/pop at count=2 for 10 cycles → count stays 2; PC sequence continuous through pointer wrap (PC 0x0..0x24).
3. Flush with 3 entries and in_valid=1 on the same cycle → next cycle count=0, out_valid=0, the flush-cycle entry absent; the next push at PC 0x100 appears as head.
4. Push PC 0x6 with in_inv_addr=1 after PC 0x0 → in_ready=0 from next cycle; decode receives 0x0 then 0x6 with out_inv_addr=1; further in_valid ignored until flush restores in_ready=1.
5. Assert rst asynchronously mid-cycle with count=3 → outputs go 0 immediately, in_ready=1, count=0 without waiting for a clock edge.
6. Pop request on empty queue with out_ready=1 for 5 cycles → count stays 0, no pointer movement; the subsequent single push appears as head one cycle later.
